// File: rtl/exmem_pipe_reg.sv
// EX/MEM pipeline register with valid/ready flow control and optional skid entry.
// Store lane formatting and alignment checks are resolved at capture time.
module exmem_pipe_reg #(
    parameter int XLEN    = 32,
    parameter int RD_W    = 5,
    parameter int SKID_EN = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                flush,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [XLEN-1:0]     in_aluresult,
    input  logic [XLEN-1:0]     in_store_data,
    input  logic [RD_W-1:0]     in_rd,
    input  logic [2:0]          in_funct3,
    input  logic                in_regwrite,
    input  logic                in_memtoreg,
    input  logic                in_memread,
    input  logic                in_memwrite,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [XLEN-1:0]     out_data_addr,
    output logic [XLEN-1:0]     out_write_data,
    output logic [XLEN/8-1:0]   out_byte_en,
    output logic [RD_W-1:0]     out_rd,
    output logic [2:0]          out_funct3,
    output logic                out_regwrite,
    output logic                out_memtoreg,
    output logic                out_memread,
    output logic                out_memwrite,
    output logic                out_misaligned
);

    localparam int BW   = XLEN / 8;
    localparam int OFFW = $clog2(BW);

    typedef struct packed {
        logic [XLEN-1:0] addr;
        logic [XLEN-1:0] wdata;
        logic [BW-1:0]   be;
        logic [RD_W-1:0] rd;
        logic [2:0]      funct3;
        logic            regwrite;
        logic            memtoreg;
        logic            memread;
        logic            memwrite;
        logic            misaligned;
    } entry_t;

    typedef enum logic [1:0] {EMPTY, ONE, TWO} state_e;

    state_e state_q, state_d;
    entry_t main_q, main_d;
    entry_t skid_q, skid_d;
    logic   in_ready_q, in_ready_d;
    entry_t fmt;

    logic [OFFW-1:0] off;
    logic [XLEN-1:0] rep;
    logic [BW-1:0]   be_raw;
    logic            mis_raw;
    logic            mis;
    logic            acc;
    logic            drn;

    always_comb begin
        off     = in_aluresult[OFFW-1:0];
        rep     = in_store_data;
        be_raw  = '0;
        mis_raw = 1'b0;
        case (in_funct3[1:0])
            2'b00: begin
                rep    = {BW{in_store_data[7:0]}};
                be_raw = BW'(1) << off;
            end
            2'b01: begin
                rep     = {(XLEN/16){in_store_data[15:0]}};
                be_raw  = BW'(2'b11) << off;
                mis_raw = off[0];
            end
            2'b10: begin
                rep     = {(XLEN/32){in_store_data[31:0]}};
                be_raw  = BW'(4'hF) << off;
                mis_raw = (off[1:0] != 2'b00);
            end
            default: begin
                rep     = in_store_data;
                be_raw  = '1;
                mis_raw = (XLEN != 64) || (off != '0);
            end
        endcase
        // ALU-only ops reuse funct3, so only memory accesses can be misaligned
        mis = mis_raw && (in_memread || in_memwrite);

        fmt            = '0;
        fmt.addr       = in_aluresult;
        fmt.wdata      = in_memwrite ? rep : in_store_data;
        fmt.be         = (in_memwrite && !mis) ? be_raw : '0;
        fmt.rd         = in_rd;
        fmt.funct3     = in_funct3;
        fmt.regwrite   = in_regwrite;
        fmt.memtoreg   = in_memtoreg;
        fmt.memread    = in_memread && !mis;
        fmt.memwrite   = in_memwrite && !mis;
        fmt.misaligned = mis;
    end

    assign out_valid = (state_q != EMPTY);
    assign in_ready  = (SKID_EN != 0) ? in_ready_q
                                      : (state_q == EMPTY) || out_ready;
    assign acc = in_valid && in_ready;
    assign drn = out_valid && out_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (acc) begin
                        state_d = ONE;
                        main_d  = fmt;
                    end
                end
                ONE: begin
                    if (acc && drn) begin
                        main_d = fmt;
                    end else if (acc) begin
                        state_d = TWO;
                        skid_d  = fmt;
                    end else if (drn) begin
                        state_d = EMPTY;
                    end
                end
                TWO: begin
                    if (drn) begin
                        state_d = ONE;
                        main_d  = skid_q;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
        in_ready_d = (state_d != TWO);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= EMPTY;
            main_q     <= '0;
            skid_q     <= '0;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            main_q     <= main_d;
            skid_q     <= skid_d;
            in_ready_q <= in_ready_d;
        end
    end

    // Data fields hold across bubbles; anything with side effects is gated
    assign out_data_addr  = main_q.addr;
    assign out_write_data = main_q.wdata;
    assign out_rd         = main_q.rd;
    assign out_funct3     = main_q.funct3;
    assign out_byte_en    = out_valid ? main_q.be : '0;
    assign out_regwrite   = out_valid && main_q.regwrite;
    assign out_memtoreg   = out_valid && main_q.memtoreg;
    assign out_memread    = out_valid && main_q.memread;
    assign out_memwrite   = out_valid && main_q.memwrite;
    assign out_misaligned = out_valid && main_q.misaligned;

endmodule

// File: tb/tb_exmem_pipe_reg.sv
// Bench for exmem_pipe_reg: vector table, scoreboard and flow-control sequences.
module tb_exmem_pipe_reg;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_aluresult = '0;
    logic [31:0] in_store_data = '0;
    logic [4:0]  in_rd = '0;
    logic [2:0]  in_funct3 = '0;
    logic        in_regwrite = 1'b0;
    logic        in_memtoreg = 1'b0;
    logic        in_memread = 1'b0;
    logic        in_memwrite = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_data_addr;
    logic [31:0] out_write_data;
    logic [3:0]  out_byte_en;
    logic [4:0]  out_rd;
    logic [2:0]  out_funct3;
    logic        out_regwrite;
    logic        out_memtoreg;
    logic        out_memread;
    logic        out_memwrite;
    logic        out_misaligned;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    exmem_pipe_reg #(.XLEN(32), .RD_W(5), .SKID_EN(1)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_aluresult(in_aluresult), .in_store_data(in_store_data),
        .in_rd(in_rd), .in_funct3(in_funct3),
        .in_regwrite(in_regwrite), .in_memtoreg(in_memtoreg),
        .in_memread(in_memread), .in_memwrite(in_memwrite),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data_addr(out_data_addr), .out_write_data(out_write_data),
        .out_byte_en(out_byte_en), .out_rd(out_rd), .out_funct3(out_funct3),
        .out_regwrite(out_regwrite), .out_memtoreg(out_memtoreg),
        .out_memread(out_memread), .out_memwrite(out_memwrite),
        .out_misaligned(out_misaligned)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [2:0]  f3;
        logic        mw;
        logic        mr;
        logic        rw;
        logic [31:0] e_wdata;
        logic [3:0]  e_be;
        logic        e_mis;
        logic        e_mw;
        logic        e_mr;
    } vec_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [4:0]  rd;
        logic        rw;
        logic        mtr;
        logic        mr;
        logic        mw;
        logic        mis;
    } exp_t;

    exp_t q[$];
    exp_t e;
    vec_t vt[10];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Byte-lane reference: lane i takes data byte (i mod size)
    function automatic exp_t model(input logic [31:0] a, input logic [31:0] d,
                                   input logic [2:0] f3, input logic mw,
                                   input logic mr, input logic rw,
                                   input logic mtr, input logic [4:0] rd);
        exp_t m;
        int nb;
        int off;
        logic ms;
        nb  = 1 << f3[1:0];
        off = int'(a[1:0]);
        ms  = (mw || mr) && (nb > 4 || (off % nb) != 0);
        m.addr  = a;
        m.rd    = rd;
        m.rw    = rw;
        m.mtr   = mtr;
        m.wdata = d;
        if (mw && nb <= 4)
            for (int i = 0; i < 4; i++) m.wdata[8*i +: 8] = d[8*(i % nb) +: 8];
        m.be = '0;
        if (mw && !ms)
            for (int i = 0; i < 4; i++) m.be[i] = (i >= off) && (i < off + nb);
        m.mis = ms;
        m.mw  = mw && !ms;
        m.mr  = mr && !ms;
        return m;
    endfunction

    always @(negedge clk) begin
        if (!rst_n || flush) begin
            q.delete();
        end else begin
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL sb_extra: got entry addr %h want none",
                             out_data_addr);
                end else begin
                    e = q.pop_front();
                    chk("sb_addr", out_data_addr, e.addr);
                    chk("sb_wdata", out_write_data, e.wdata);
                    chk("sb_be", {28'd0, out_byte_en}, {28'd0, e.be});
                    chk("sb_rd", {27'd0, out_rd}, {27'd0, e.rd});
                    chk("sb_ctl",
                        {27'd0, out_regwrite, out_memtoreg, out_memread,
                         out_memwrite, out_misaligned},
                        {27'd0, e.rw, e.mtr, e.mr, e.mw, e.mis});
                end
            end
            if (in_valid && in_ready)
                q.push_back(model(in_aluresult, in_store_data, in_funct3,
                                  in_memwrite, in_memread, in_regwrite,
                                  in_memtoreg, in_rd));
        end
    end

    task automatic drive(input logic v, input logic [31:0] a,
                         input logic [31:0] d, input logic [2:0] f3,
                         input logic mw, input logic mr, input logic rw,
                         input logic [4:0] rd);
        in_valid      = v;
        in_aluresult  = a;
        in_store_data = d;
        in_funct3     = f3;
        in_memwrite   = mw;
        in_memread    = mr;
        in_regwrite   = rw;
        in_memtoreg   = mr;
        in_rd         = rd;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_bubble(input string nm);
        chk({nm, "_valid"}, {31'd0, out_valid}, 32'd0);
        chk({nm, "_ctl"},
            {27'd0, out_regwrite, out_memtoreg, out_memread,
             out_memwrite, out_misaligned}, 32'd0);
        chk({nm, "_be"}, {28'd0, out_byte_en}, 32'd0);
    endtask

    task automatic fill_two(input logic [31:0] a0, input logic [31:0] a1);
        out_ready = 1'b0;
        drive(1'b1, a0, 32'h0000_00A5, 3'd0, 1'b1, 1'b0, 1'b0, 5'd3);
        step();
        drive(1'b1, a1, 32'h0000_5A5A, 3'd1, 1'b1, 1'b0, 1'b1, 5'd4);
        step();
        chk("two_in_ready", {31'd0, in_ready}, 32'd0);
        chk("two_head", out_data_addr, a0);
    endtask

    initial begin
        vt[0] = '{32'h103, 32'h0000_00AB, 3'd0, 1'b1, 1'b0, 1'b0,
                  32'hABAB_ABAB, 4'b1000, 1'b0, 1'b1, 1'b0};
        vt[1] = '{32'h102, 32'h1234_5678, 3'd2, 1'b1, 1'b0, 1'b0,
                  32'h1234_5678, 4'b0000, 1'b1, 1'b0, 1'b0};
        vt[2] = '{32'h102, 32'h0000_BEEF, 3'd1, 1'b1, 1'b0, 1'b0,
                  32'hBEEF_BEEF, 4'b1100, 1'b0, 1'b1, 1'b0};
        vt[3] = '{32'h101, 32'h0000_1234, 3'd1, 1'b1, 1'b0, 1'b0,
                  32'h1234_1234, 4'b0000, 1'b1, 1'b0, 1'b0};
        vt[4] = '{32'h100, 32'hCAFE_F00D, 3'd2, 1'b1, 1'b0, 1'b0,
                  32'hCAFE_F00D, 4'b1111, 1'b0, 1'b1, 1'b0};
        vt[5] = '{32'h104, 32'h55AA_55AA, 3'd3, 1'b1, 1'b0, 1'b0,
                  32'h55AA_55AA, 4'b0000, 1'b1, 1'b0, 1'b0};
        vt[6] = '{32'h203, 32'h0000_0077, 3'd1, 1'b0, 1'b1, 1'b1,
                  32'h0000_0077, 4'b0000, 1'b1, 1'b0, 1'b0};
        vt[7] = '{32'h204, 32'h0000_0099, 3'd2, 1'b0, 1'b1, 1'b1,
                  32'h0000_0099, 4'b0000, 1'b0, 1'b0, 1'b1};
        vt[8] = '{32'h007, 32'h0000_0000, 3'd3, 1'b0, 1'b0, 1'b1,
                  32'h0000_0000, 4'b0000, 1'b0, 1'b0, 1'b0};
        vt[9] = '{32'h101, 32'h0000_01FF, 3'd0, 1'b1, 1'b0, 1'b0,
                  32'hFFFF_FFFF, 4'b0010, 1'b0, 1'b1, 1'b0};

        repeat (3) @(posedge clk);
        #1;
        chk_bubble("rst");
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_addr", out_data_addr, 32'd0);
        rst_n = 1'b1;

        out_ready = 1'b1;
        drive(1'b1, 32'h100, 32'h0, 3'd0, 1'b0, 1'b0, 1'b1, 5'd5);
        step();
        chk("s1_valid", {31'd0, out_valid}, 32'd1);
        chk("s1_addr", out_data_addr, 32'h100);
        chk("s1_rd", {27'd0, out_rd}, 32'd5);
        chk("s1_rw", {31'd0, out_regwrite}, 32'd1);
        chk("s1_in_ready", {31'd0, in_ready}, 32'd1);

        for (int i = 0; i < 10; i++) begin
            drive(1'b1, vt[i].addr, vt[i].data, vt[i].f3, vt[i].mw,
                  vt[i].mr, vt[i].rw, 5'(i + 1));
            step();
            chk($sformatf("v%0d_addr", i), out_data_addr, vt[i].addr);
            chk($sformatf("v%0d_wdata", i), out_write_data, vt[i].e_wdata);
            chk($sformatf("v%0d_be", i), {28'd0, out_byte_en},
                {28'd0, vt[i].e_be});
            chk($sformatf("v%0d_ctl", i),
                {28'd0, out_misaligned, out_memwrite, out_memread,
                 out_regwrite},
                {28'd0, vt[i].e_mis, vt[i].e_mw, vt[i].e_mr, vt[i].rw});
        end
        drive(1'b0, 32'h0, 32'h0, 3'd0, 1'b0, 1'b0, 1'b0, 5'd0);
        step();
        chk_bubble("tail");
        chk("tail_hold_addr", out_data_addr, 32'h101);

        for (int c = 0; c < 300; c++) begin
            out_ready = 1'($urandom_range(0, 1));
            drive(1'($urandom_range(0, 1)), $urandom(), $urandom(),
                  3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  5'($urandom_range(0, 31)));
            step();
        end
        drive(1'b0, 32'h0, 32'h0, 3'd0, 1'b0, 1'b0, 1'b0, 5'd0);
        out_ready = 1'b1;
        repeat (4) step();
        chk("rand_drained", q.size(), 32'd0);

        fill_two(32'h10, 32'h20);
        drive(1'b1, 32'h99, 32'h0, 3'd0, 1'b0, 1'b0, 1'b1, 5'd9);
        step();
        chk("bp_hold_ready", {31'd0, in_ready}, 32'd0);
        drive(1'b0, 32'h0, 32'h0, 3'd0, 1'b0, 1'b0, 1'b0, 5'd0);
        out_ready = 1'b1;
        step();
        chk("bp_second", out_data_addr, 32'h20);
        chk("bp_second_v", {31'd0, out_valid}, 32'd1);
        step();
        chk("bp_empty", {31'd0, out_valid}, 32'd0);
        chk("bp_ready", {31'd0, in_ready}, 32'd1);

        fill_two(32'h41, 32'h52);
        flush = 1'b1;
        drive(1'b1, 32'h30, 32'hAB, 3'd0, 1'b1, 1'b0, 1'b1, 5'd7);
        step();
        flush = 1'b0;
        chk_bubble("flush");
        chk("flush_in_ready", {31'd0, in_ready}, 32'd1);
        drive(1'b0, 32'h0, 32'h0, 3'd0, 1'b0, 1'b0, 1'b0, 5'd0);
        out_ready = 1'b1;
        repeat (3) begin
            step();
            chk("flush_no_c", {31'd0, out_valid}, 32'd0);
        end

        fill_two(32'h61, 32'h72);
        drive(1'b0, 32'h0, 32'h0, 3'd0, 1'b0, 1'b0, 1'b0, 5'd0);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk_bubble("arst");
        chk("arst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("arst_addr", out_data_addr, 32'd0);
        chk("arst_wdata", out_write_data, 32'd0);
        step();
        rst_n = 1'b1;
        step();
        chk("arst_stays_empty", {31'd0, out_valid}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/exmem_pipe_reg.md
Name: exmem_pipe_reg

Overview:
Parametrised EX/MEM pipeline register for the RISC-V core. It adds valid/ready flow control, a 2-entry skid buffer, synchronous flush, and bubble-qualified control outputs. It also formats stores: lane replication, byte enables and misalignment detection, computed at capture time. It sits between the ALU/forwarding mux output and the data memory / MEM-WB register.

Parameters:
XLEN, 32, datapath width; legal values are 32 and 64.
RD_W, 5, destination register index width.
SKID_EN, 1, 1 = two-entry skid buffer (in_ready registered); 0 = single entry (in_ready combinational).

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
flush  in  1  synchronous kill of all held and incoming entries
in_valid  in  1  EX stage has an instruction
in_ready  out  1  stage can accept this cycle
in_aluresult  in  XLEN  ALU result / memory address
in_store_data  in  XLEN  rs2 value after forwarding mux
in_rd  in  RD_W  destination register
in_funct3  in  3  load/store size and sign
in_regwrite, in_memtoreg, in_memread, in_memwrite  in  1 each  control bits
out_valid  out  1  entry presented to MEM
out_ready  in  1  MEM consumes entry
out_data_addr  out  XLEN  registered address
out_write_data  out  XLEN  lane-replicated store data
out_byte_en  out  XLEN/8  store byte enables
out_rd  out  RD_W  destination register
out_funct3  out  3  passed through
out_regwrite, out_memtoreg, out_memread, out_memwrite  out  1 each  valid-qualified control bits
out_misaligned  out  1  access violates natural alignment

Behaviour:
- Reset (rst_n low, async): all valid bits 0; every out_* data/control output 0; in_ready = 1. Deassertion is taken on the next clk edge.
- Accept occurs when in_valid && in_ready. Drain occurs when out_valid && out_ready. Latency is 1 cycle from accept into an empty stage to out_valid.
- SKID_EN=1 state machine:
  - EMPTY: accept -> ONE.
  - ONE: accept with no drain -> TWO (new entry goes to skid). Drain with no accept -> EMPTY. Both -> ONE (main reloads from input).
  - TWO: drain -> ONE (main <- skid). No drain -> hold.
  - in_ready = (state != TWO), registered. No input is lost when out_ready drops while in_valid is high.
- SKID_EN=0: single entry; in_ready = !out_valid || out_ready.
- flush has priority over everything. On the next edge, state = EMPTY and all valid bits clear. An input offered in the flush cycle is dropped. in_ready = 1 the following cycle.
- Bubble rule: when out_valid = 0, out_regwrite, out_memtoreg, out_memread, out_memwrite, out_misaligned and out_byte_en are forced to 0. Data fields hold their last value.
- Store formatting, computed from in_* at accept and stored with the entry. off = addr[log2(XLEN/8)-1:0].
  - size 00 (byte): data byte replicated to all lanes; byte_en = 1 << off.
  - size 01 (half): halfword replicated; byte_en = 2'b11 << off; misaligned if off[0].
  - size 10 (word): word replicated (XLEN=64); byte_en = 4'hF << off; misaligned if off[1:0] != 0.
  - size 11 (double): legal only at XLEN=64, byte_en all ones, misaligned if off != 0. At XLEN=32, size 11 sets misaligned.
- If in_memwrite = 0, byte_en = 0 and write_data passes unformatted.
- Misalignment applies to loads and stores. When misaligned: out_misaligned = 1, out_memwrite and out_memread forced to 0, byte_en = 0, and regwrite passes through unchanged (the trap unit owns the response).
- Simultaneous flush and rst_n low: reset wins.

Test Plan:
1. Reset then stream: rst_n low 3 cycles, then in_valid=1 with aluresult=0x100, rd=5, regwrite=1, out_ready=1 -> out_valid=1 next cycle, out_data_addr=0x100, out_rd=5, out_regwrite=1; in_ready stays 1.
2. Backpressure (SKID_EN=1): out_ready=0, inject A=0x10 then B=0x20 -> in_ready low after B. Raise out_ready -> A then B appear in order on consecutive cycles, no loss or duplication.
3. Flush in state TWO, same cycle as in_valid with C -> next cycle out_valid=0, all control outputs 0, in_ready=1; C never appears.
4. Store byte at addr 0x103, data 0x000000AB, memwrite=1, funct3=000 -> out_write_data=0xABABABAB, out_byte_en=4'b1000, out_misaligned=0.
5. Store word at 0x102 (funct3=010) -> out_misaligned=1, out_memwrite=0, out_byte_en=0. Half at 0x102 -> byte_en=4'b1100, misaligned=0.
6. Async reset mid-stream: pulse rst_n low between clock edges while in TWO -> outputs go to 0 immediately without waiting for clk; in_ready=1.
